wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the RISC-V core; it is the single writer of `reg_file`. It merges single-cycle ALU results with multi-cycle load returns into one registered write port. It buffers load returns in a small queue and keeps a per-register pending scoreboard so decode can stall on outstanding loads. It sits between the execute/memory stages and the register file's `write_en` / `write_add` / `write_data` inputs.

## Interface
Parameters:
- `N`, 32: data width.
- `LQ_DEPTH`, 2: load queue entries; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `iss_valid`, in, 1: a load is being issued this cycle.
- `iss_rd`, in, 5: destination of the issued load.
- `alu_valid`, in, 1: ALU result present; always accepted.
- `alu_rd`, in, 5: ALU destination register.
- `alu_data`, in, N: ALU result.
- `ld_valid`, in, 1: load return valid.
- `ld_ready`, out, 1: load queue can accept an entry.
- `ld_rd`, in, 5: load destination register.
- `ld_data`, in, N: load data.
- `alu_stall_req`, out, 1: request one ALU bubble so loads can drain.
- `rf_write_en`, out, 1: drives the register file `write_en`.
- `rf_write_add`, out, 5: drives the register file `write_add`.
- `rf_write_data`, out, N: drives the register file `write_data`.
- `pending`, out, 32: scoreboard; bit r set means a load to xr is outstanding.
- `lq_count`, out, $clog2(LQ_DEPTH)+1: current queue occupancy.

## Operation
- **Load queue.** FIFO with read and write pointers that wrap modulo `LQ_DEPTH`.
  - Push when `ld_valid && ld_ready`.
  - `ld_ready = (lq_count < LQ_DEPTH)`, registered.
  - Pop happens when the head is selected for writeback.
  - Push and pop in the same cycle leave the count unchanged. This is legal even when the queue is full, because `ld_ready` reflects the previous cycle.
- **Select, once per cycle.**
  - If `alu_valid` and `alu_rd != 0`: ALU wins.
  - Otherwise, if the queue is non-empty: the queue head wins and is popped.
  - Otherwise: no write.
- **x0 handling.**
  - An ALU result with `alu_rd == 0` is discarded; the queue head may use that cycle.
  - A queue entry with rd 0 is popped with `rf_write_en` held 0.
- **Stall request.** `alu_stall_req` = 1 when the queue is full and `alu_valid` was 1 in the previous cycle. The pipeline must then deliver `alu_valid` = 0 for at least one cycle.
- **Scoreboard.**
  - `pending[iss_rd]` is set on `iss_valid` when `iss_rd != 0`.
  - `pending[r]` is cleared when a load write to r is committed (selected).
  - Set and clear of the same r in one cycle: set wins.
  - `pending[0]` is always 0.
- **Out-of-order returns.** Returns are not checked against `pending`. A return to a non-pending rd still writes.

## Timing
- **Reset.** Queue empty, `lq_count` = 0, `ld_ready` = 1, `alu_stall_req` = 0, `rf_write_en` = 0, `rf_write_add` = 0, `rf_write_data` = 0, `pending` = 0.
- **Write latency.** 1 cycle: a selection in cycle t appears on the `rf_write_*` outputs in cycle t+1 and commits to `reg_file` at the edge ending t+1.
- **Load path.** A queued load is written no earlier than 1 cycle after push; there is no same-cycle pass-through.
- **Scoreboard timing.** A `pending` clear is visible in the cycle after selection, together with `rf_write_en`.
- **Reset mid-operation.** Queue contents and pending bits are discarded. Outputs go to their reset values asynchronously; no partial write is emitted.

## Configuration
- `WB_BYPASS_EN` defined: adds outputs `byp_valid` (1), `byp_rd` (5) and `byp_data` (N). These combinationally present the write selected in the current cycle, one cycle before `rf_write_*`, so decode can forward.
- `WB_BYPASS_EN` undefined: those ports and their logic do not exist.

## Structure
- Shared package `core_pkg`:
  - `reg_addr_t` (5-bit).
  - `XLEN` constant.
  - `wb_entry_t` struct {rd, data}.
- One sub-module, `wb_load_fifo`: parameterised FIFO of `wb_entry_t` providing count, full and empty.

## Test plan
- **Reset.** Hold `reset_n` = 0 for 3 cycles, then release -> `ld_ready` = 1, `pending` = 0, `rf_write_en` = 0, `lq_count` = 0.
- **ALU only.** `alu_valid`, rd 5, data 0xDEADBEEF -> next cycle `rf_write_en` = 1, `rf_write_add` = 5, `rf_write_data` = 0xDEADBEEF. The same stimulus with rd 0 -> `rf_write_en` = 0.
- **Collision.** Issue a load to x7 -> `pending[7]` = 1. Then `ld_valid` (rd 7, data 0x11) in the same cycle as an ALU write (rd 3, data 0x22) -> x3 written first, x7 the following cycle, with `pending[7]` clearing in that cycle.
- **Full queue.** ALU busy every cycle and 2 loads pushed -> `ld_ready` = 0, `alu_stall_req` = 1. After one ALU bubble: head drained, `lq_count` = 1, `ld_ready` = 1.
- **Set wins.** Same-cycle `iss_valid` (rd 9) and commit of a load to x9 -> `pending[9]` stays 1.
- **Reset mid-operation.** 2 loads queued, `reset_n` pulsed low -> queue empty, no write emitted, all outputs at reset values.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types used by the writeback path.
package core_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Small FIFO of writeback entries for returning loads. Depth must be a power of two >= 2.
module wb_load_fifo
    import core_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  wb_entry_t                  wdata_i,
    input  logic                       pop_i,
    output wb_entry_t                  rdata_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic [$clog2(Depth):0]     count_next_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    wb_entry_t         mem_q [Depth];
    wb_entry_t         mem_d [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full_o       = (count_q == CntW'(Depth));
    assign empty_o      = (count_q == '0);
    assign rdata_o      = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

    // Next-state: pointers wrap naturally at the power-of-two depth.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A push into a full FIFO is only safe when the head leaves in the same cycle.
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any queued entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and queued load returns into one registered
// register-file write port, and tracks outstanding loads per register.
// Optional feature macro WB_BYPASS_EN adds byp_valid/byp_rd/byp_data forwarding outputs.
// N must not exceed core_pkg::XLEN.
module wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        iss_valid,
    input  logic [4:0]                  iss_rd,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [N-1:0]                alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [4:0]                  ld_rd,
    input  logic [N-1:0]                ld_data,
    output logic                        alu_stall_req,
    output logic                        rf_write_en,
    output logic [4:0]                  rf_write_add,
    output logic [N-1:0]                rf_write_data,
    output logic [31:0]                 pending,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
`ifdef WB_BYPASS_EN
    ,
    output logic                        byp_valid,
    output logic [4:0]                  byp_rd,
    output logic [N-1:0]                byp_data
`endif
);

    localparam int unsigned CntW = $clog2(LQ_DEPTH) + 1;

    wb_entry_t         lq_wdata;
    wb_entry_t         lq_head;
    logic [CntW-1:0]   lq_cnt, lq_cnt_next;
    logic              lq_full, lq_empty;
    logic              lq_push, lq_sel, alu_sel;

    logic              ld_ready_q, ld_ready_d;
    logic              alu_valid_q, alu_valid_d;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_add_q, wr_add_d;
    logic [N-1:0]      wr_data_q, wr_data_d;
    logic [31:0]       pending_q, pending_d;

    assign lq_push       = ld_valid && ld_ready_q;
    assign lq_wdata.rd   = ld_rd;
    assign lq_wdata.data = XLEN'(ld_data);

    wb_load_fifo #(
        .Depth (LQ_DEPTH)
    ) u_load_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (lq_push),
        .wdata_i      (lq_wdata),
        .pop_i        (lq_sel),
        .rdata_o      (lq_head),
        .count_o      (lq_cnt),
        .count_next_o (lq_cnt_next),
        .full_o       (lq_full),
        .empty_o      (lq_empty)
    );

    // Select one writer per cycle: ALU first, else the queue head; also update the scoreboard.
    always_comb begin
        alu_sel     = alu_valid && (alu_rd != 5'd0);
        lq_sel      = !alu_sel && !lq_empty;
        wr_en_d     = 1'b0;
        wr_add_d    = '0;
        wr_data_d   = '0;
        pending_d   = pending_q;
        alu_valid_d = alu_valid;
        ld_ready_d  = (lq_cnt_next < CntW'(LQ_DEPTH));
        if (alu_sel) begin
            wr_en_d   = 1'b1;
            wr_add_d  = alu_rd;
            wr_data_d = alu_data;
        end else if (lq_sel) begin
            // A load to x0 still pops, but never writes.
            wr_en_d   = (lq_head.rd != 5'd0);
            wr_add_d  = lq_head.rd;
            wr_data_d = lq_head.data[N-1:0];
            pending_d[lq_head.rd] = 1'b0;
        end
        // A new issue to the same register overrides the clear.
        if (iss_valid && (iss_rd != 5'd0)) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Registered write port, scoreboard and flow-control state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_ready_q  <= 1'b1;
            alu_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_add_q    <= '0;
            wr_data_q   <= '0;
            pending_q   <= '0;
        end else begin
            ld_ready_q  <= ld_ready_d;
            alu_valid_q <= alu_valid_d;
            wr_en_q     <= wr_en_d;
            wr_add_q    <= wr_add_d;
            wr_data_q   <= wr_data_d;
            pending_q   <= pending_d;
        end
    end

    assign ld_ready      = ld_ready_q;
    // Ask for an ALU bubble when the queue is full and the ALU kept it from draining.
    assign alu_stall_req = lq_full && alu_valid_q;
    assign rf_write_en   = wr_en_q;
    assign rf_write_add  = wr_add_q;
    assign rf_write_data = wr_data_q;
    assign pending       = pending_q;
    assign lq_count      = lq_cnt;

`ifdef WB_BYPASS_EN
    assign byp_valid = wr_en_d;
    assign byp_rd    = wr_add_d;
    assign byp_data  = wr_data_d;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_wb_arbiter;

    localparam int N = 32;
    localparam int D = 2;

    logic          clk;
    logic          reset_n;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [N-1:0]  alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [4:0]    ld_rd;
    logic [N-1:0]  ld_data;
    logic          alu_stall_req;
    logic          rf_write_en;
    logic [4:0]    rf_write_add;
    logic [N-1:0]  rf_write_data;
    logic [31:0]   pending;
    logic [1:0]    lq_count;

    int checks;
    int errors;

    wb_arbiter #(
        .N        (N),
        .LQ_DEPTH (D)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .alu_stall_req (alu_stall_req),
        .rf_write_en   (rf_write_en),
        .rf_write_add  (rf_write_add),
        .rf_write_data (rf_write_data),
        .pending       (pending),
        .lq_count      (lq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    typedef struct {
        logic [4:0]   rd;
        logic [N-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic [31:0]   m_pending;
    logic          m_ready;
    logic          m_prev_alu;
    logic          m_en;
    logic [4:0]    m_add;
    logic [N-1:0]  m_data;

    task automatic model_reset();
        mq.delete();
        m_pending  = '0;
        m_ready    = 1'b1;
        m_prev_alu = 1'b0;
        m_en       = 1'b0;
        m_add      = '0;
        m_data     = '0;
    endtask

    function automatic logic m_stall();
        return (mq.size() == D) && m_prev_alu;
    endfunction

    task automatic set_idle();
        iss_valid = 1'b0; iss_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd = '0;  ld_data = '0;
    endtask

    // Advance model and DUT by one clock with the currently driven inputs.
    task automatic step();
        ent_t h;
        logic push;
        push = ld_valid && m_ready;
        m_en = 1'b0;
        if (alu_valid && alu_rd != 5'd0) begin
            m_en = 1'b1; m_add = alu_rd; m_data = alu_data;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_pending[h.rd] = 1'b0;
            if (h.rd != 5'd0) begin
                m_en = 1'b1; m_add = h.rd; m_data = h.data;
            end
        end
        if (push) begin
            h.rd = ld_rd; h.data = ld_data;
            mq.push_back(h);
        end
        if (iss_valid && iss_rd != 5'd0) m_pending[iss_rd] = 1'b1;
        m_pending[0] = 1'b0;
        m_ready    = (mq.size() < D);
        m_prev_alu = alu_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rf_write_en !== 1'b0) begin
            errors++; $display("FAIL reset_hold_en: got %0b want 0", rf_write_en);
        end
        reset_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ld_ready: got %0b want 1", ld_ready);
        end
        checks++;
        if (pending !== 32'h0) begin
            errors++; $display("FAIL reset_pending: got %h want 0", pending);
        end
        checks++;
        if (lq_count !== 2'd0 || alu_stall_req !== 1'b0) begin
            errors++; $display("FAIL reset_count_stall: got %0d/%0b want 0/0", lq_count, alu_stall_req);
        end
        checks++;
        if (rf_write_add !== 5'd0 || rf_write_data !== '0 || rf_write_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_port: got %0b/%0d/%h want 0/0/0",
                     rf_write_en, rf_write_add, rf_write_data);
        end
    endtask

    task automatic test_alu_only();
        set_idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_add !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_write: got %0b/%0d/%h want 1/5/deadbeef",
                     rf_write_en, rf_write_add, rf_write_data);
        end
        alu_rd = 5'd0;
        step();
        checks++;
        if (rf_write_en !== 1'b0) begin
            errors++; $display("FAIL alu_x0_discard: got en %0b want 0", rf_write_en);
        end
        set_idle();
        step();
    endtask

    task automatic test_collision();
        set_idle();
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        checks++;
        if (pending[7] !== 1'b1) begin
            errors++; $display("FAIL coll_pending_set: got %0b want 1", pending[7]);
        end
        set_idle();
        ld_valid  = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
        step();
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_add !== 5'd3 || rf_write_data !== 32'h22
            || pending[7] !== 1'b1 || lq_count !== 2'd1) begin
            errors++;
            $display("FAIL coll_alu_first: got %0b/%0d/%h p7=%0b cnt=%0d want 1/3/22 p7=1 cnt=1",
                     rf_write_en, rf_write_add, rf_write_data, pending[7], lq_count);
        end
        set_idle();
        step();
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_add !== 5'd7 || rf_write_data !== 32'h11
            || pending[7] !== 1'b0 || lq_count !== 2'd0) begin
            errors++;
            $display("FAIL coll_load_second: got %0b/%0d/%h p7=%0b cnt=%0d want 1/7/11 p7=0 cnt=0",
                     rf_write_en, rf_write_add, rf_write_data, pending[7], lq_count);
        end
    endtask

    task automatic test_full_queue();
        set_idle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0;
        ld_valid  = 1'b1; ld_rd = 5'd10; ld_data = 32'hAAAA_0001;
        step();
        alu_data = 32'hA1;
        ld_rd = 5'd11; ld_data = 32'hBBBB_0002;
        step();
        checks++;
        if (ld_ready !== 1'b0 || alu_stall_req !== 1'b1 || lq_count !== 2'd2) begin
            errors++;
            $display("FAIL full_state: got rdy=%0b stall=%0b cnt=%0d want 0/1/2",
                     ld_ready, alu_stall_req, lq_count);
        end
        set_idle();
        step();
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_add !== 5'd10 || rf_write_data !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL full_drain_head: got %0b/%0d/%h want 1/10/aaaa0001",
                     rf_write_en, rf_write_add, rf_write_data);
        end
        checks++;
        if (lq_count !== 2'd1 || ld_ready !== 1'b1 || alu_stall_req !== 1'b0) begin
            errors++;
            $display("FAIL full_after_bubble: got cnt=%0d rdy=%0b stall=%0b want 1/1/0",
                     lq_count, ld_ready, alu_stall_req);
        end
        step();
        checks++;
        if (rf_write_add !== 5'd11 || rf_write_data !== 32'hBBBB_0002 || lq_count !== 2'd0) begin
            errors++;
            $display("FAIL full_drain_tail: got %0d/%h cnt=%0d want 11/bbbb0002 cnt=0",
                     rf_write_add, rf_write_data, lq_count);
        end
    endtask

    task automatic test_set_wins();
        set_idle();
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        set_idle();
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        step();
        set_idle();
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        checks++;
        if (rf_write_en !== 1'b1 || rf_write_add !== 5'd9 || pending[9] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got en=%0b add=%0d p9=%0b want 1/9/1",
                     rf_write_en, rf_write_add, pending[9]);
        end
        set_idle();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_valid = m_stall() ? 1'b0 : ($urandom_range(0, 1) == 1);
            alu_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 2) != 0);
            ld_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ld_data   = $urandom;
            step();
            checks++;
            if (rf_write_en !== m_en || (m_en && (rf_write_add !== m_add || rf_write_data !== m_data))) begin
                errors++;
                $display("FAIL rand_write[%0d]: got %0b/%0d/%h want %0b/%0d/%h", i,
                         rf_write_en, rf_write_add, rf_write_data, m_en, m_add, m_data);
            end
            checks++;
            if (pending !== m_pending) begin
                errors++; $display("FAIL rand_pending[%0d]: got %h want %h", i, pending, m_pending);
            end
            checks++;
            if (lq_count !== 2'(mq.size()) || ld_ready !== m_ready || alu_stall_req !== m_stall()) begin
                errors++;
                $display("FAIL rand_flow[%0d]: got cnt=%0d rdy=%0b stall=%0b want %0d/%0b/%0b", i,
                         lq_count, ld_ready, alu_stall_req, mq.size(), m_ready, m_stall());
            end
        end
        set_idle();
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        set_idle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h5;
        iss_valid = 1'b1; iss_rd = 5'd12;
        ld_valid  = 1'b1; ld_rd = 5'd12; ld_data = 32'hC0C0;
        step();
        iss_valid = 1'b0;
        ld_rd = 5'd13; ld_data = 32'hD0D0;
        step();
        checks++;
        if (lq_count !== 2'd2 || pending[12] !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got cnt=%0d p12=%0b want 2/1", lq_count, pending[12]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (rf_write_en !== 1'b0 || rf_write_add !== 5'd0 || rf_write_data !== '0
            || lq_count !== 2'd0 || ld_ready !== 1'b1 || pending !== 32'h0
            || alu_stall_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: en=%0b add=%0d data=%h cnt=%0d rdy=%0b pend=%h stall=%0b",
                     rf_write_en, rf_write_add, rf_write_data, lq_count, ld_ready, pending,
                     alu_stall_req);
        end
        set_idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        step();
        checks++;
        if (rf_write_en !== 1'b0 || lq_count !== 2'd0 || pending !== 32'h0) begin
            errors++;
            $display("FAIL mid_after: got en=%0b cnt=%0d pend=%h want 0/0/0",
                     rf_write_en, lq_count, pending);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_alu_only();
        test_collision();
        test_full_queue();
        test_set_wins();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
